// File: rtl/spi_pkg.sv
// Shared types and command encodings for the parametrised SPI slave.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RD_SHIFT  = 3'd6,
    ST_DONE      = 3'd7
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial MISO shifter: load emits the first bit on the next cycle,
// each shift_en emits the next one; MISO returns to 0 when idle.
module spi_tx_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              shift_en,
  output logic              miso,
  output logic              done_c
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  // cnt holds the number of bits still to be presented after the current one
  assign done_c = (cnt == '0);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      miso <= 1'b0;
    end else if (load) begin
      cnt <= CNT_W'(DATA_W - 1);
      if (LSB_FIRST) begin
        miso <= data[0];
        sreg <= data >> 1;
      end else begin
        miso <= data[DATA_W-1];
        sreg <= data << 1;
      end
    end else if (shift_en && !done_c) begin
      cnt <= cnt - CNT_W'(1);
      if (LSB_FIRST) begin
        miso <= sreg[0];
        sreg <= sreg >> 1;
      end else begin
        miso <= sreg[DATA_W-1];
        sreg <= sreg << 1;
      end
    end else begin
      miso <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames into rx_data and
// returns tx_data on MISO for read-data frames, with abort/timeout reporting.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned BC_W    = $clog2(FRAME_W + 1);
  localparam int unsigned TO_W    = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

  spi_state_e         state, state_d;
  logic [BC_W-1:0]    bit_cnt, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt, to_cnt_d;
  logic [FRAME_W-2:0] sr, sr_d;
  logic [FRAME_W-1:0] sr_next, rx_word;
  logic [FRAME_W-1:0] rx_data_d;
  logic               rx_valid_d, frame_err_d;
  logic               rd_addr_seen, rd_addr_seen_d;
  logic               tx_load_c, tx_shift_c, tx_done_c;

  // Received bits in arrival order; payload reversed back to natural order when LSB-first
  always_comb begin
    sr_next = {sr, MOSI};
    rx_word = sr_next;
    if (LSB_FIRST) begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        rx_word[i] = sr_next[int'(DATA_W) - 1 - i];
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_seen <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      bit_cnt      <= bit_cnt_d;
      to_cnt       <= to_cnt_d;
      sr           <= sr_d;
      rx_data      <= rx_data_d;
      rx_valid     <= rx_valid_d;
      frame_err    <= frame_err_d;
      rd_addr_seen <= rd_addr_seen_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d        = state;
    bit_cnt_d      = bit_cnt;
    to_cnt_d       = to_cnt;
    sr_d           = sr;
    rx_data_d      = rx_data;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    rd_addr_seen_d = rd_addr_seen;
    tx_load_c      = 1'b0;
    tx_shift_c     = 1'b0;

    // Deselect wins over everything, including a final bit on the same edge
    if (SS_n) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      frame_err_d = (state != ST_IDLE) && (state != ST_DONE);
    end else begin
      case (state)
        ST_IDLE: state_d = ST_CHK_CMD;
        ST_CHK_CMD: begin
          sr_d      = sr_next[FRAME_W-2:0];
          bit_cnt_d = BC_W'(1);
          if (MOSI == CMD_RD_ADDR[1]) begin
            state_d = rd_addr_seen ? ST_READ_DATA : ST_READ_ADD;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          sr_d      = sr_next[FRAME_W-2:0];
          bit_cnt_d = bit_cnt + BC_W'(1);
          if (bit_cnt == BC_W'(FRAME_W - 1)) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            if (state == ST_READ_DATA) begin
              state_d        = ST_RD_WAIT;
              rd_addr_seen_d = 1'b0;
              to_cnt_d       = '0;
            end else begin
              state_d = ST_DONE;
              if (state == ST_READ_ADD) rd_addr_seen_d = 1'b1;
            end
          end
        end
        ST_RD_WAIT: begin
          if (tx_valid) begin
            tx_load_c = 1'b1;
            to_cnt_d  = '0;
            state_d   = ST_RD_SHIFT;
          end else if (TX_TIMEOUT != 0) begin
            if (to_cnt == TO_W'(TX_TIMEOUT - 1)) begin
              frame_err_d = 1'b1;
              to_cnt_d    = '0;
              state_d     = ST_DONE;
            end else begin
              to_cnt_d = to_cnt + TO_W'(1);
            end
          end
        end
        ST_RD_SHIFT: begin
          tx_shift_c = 1'b1;
          if (tx_done_c) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  spi_tx_serializer #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_tx (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .load    (tx_load_c),
    .data    (tx_data),
    .shift_en(tx_shift_c),
    .miso    (MISO),
    .done_c  (tx_done_c)
  );

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: 8-bit MSB-first and 16-bit LSB-first instances.
module tb_spi_slave_param;
  import spi_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n8, ss8, mosi8, miso8, rxv8, txv8, err8, busy8;
  logic [9:0]  rx8;
  logic [7:0]  txd8;
  logic        rst_n16, ss16, mosi16, miso16, rxv16, txv16, err16, busy16;
  logic [17:0] rx16;
  logic [15:0] txd16;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(16)) dut8 (
    .CLK(CLK), .rst_n(rst_n8), .SS_n(ss8), .MOSI(mosi8), .MISO(miso8),
    .rx_data(rx8), .rx_valid(rxv8), .tx_data(txd8), .tx_valid(txv8),
    .frame_err(err8), .busy(busy8)
  );

  spi_slave_param #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_TIMEOUT(16)) dut16 (
    .CLK(CLK), .rst_n(rst_n16), .SS_n(ss16), .MOSI(mosi16), .MISO(miso16),
    .rx_data(rx16), .rx_valid(rxv16), .tx_data(txd16), .tx_valid(txv16),
    .frame_err(err16), .busy(busy16)
  );

  int total = 0;
  int bad   = 0;
  int nv[2], ne[2], mh[2], bl[2];
  logic [9:0]  rxl8;
  logic [17:0] rxl16;

  typedef struct {
    logic [9:0] frame;
    logic [9:0] exp_rx;
  } vec_t;
  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int s = 0; s < 2; s++) begin
      nv[s] = 0; ne[s] = 0; mh[s] = 0; bl[s] = 0;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rxv8) begin nv[0]++; rxl8 = rx8; end
    if (err8) ne[0]++;
    if (miso8) mh[0]++;
    if (rxv16) begin nv[1]++; rxl16 = rx16; end
    if (err16) ne[1]++;
    if (miso16) mh[1]++;
  endtask

  // Bits are sent from txv[fw-1] downwards: start cycle, then nbits data cycles
  task automatic send(input int sel, input logic [17:0] txv, input int fw, input int nbits);
    if (sel == 0) ss8 = 1'b0; else ss16 = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) mosi8 = txv[fw-1-i]; else mosi16 = txv[fw-1-i];
      tick();
      if ((sel == 0) ? !busy8 : !busy16) bl[sel]++;
    end
  endtask

  task automatic end_frame(input int sel);
    if (sel == 0) begin ss8 = 1'b1; mosi8 = 1'b0; end
    else begin ss16 = 1'b1; mosi16 = 1'b0; end
    tick();
    tick();
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  initial begin
    logic [7:0]  a5;
    logic [15:0] p16;
    int          k;
    bit          found;

    rst_n8 = 1'b0; ss8 = 1'b1; mosi8 = 1'b0; txv8 = 1'b0; txd8 = '0;
    rst_n16 = 1'b0; ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = '0;
    rxl8 = '0; rxl16 = '0;
    clr();
    tick(); tick();
    check("rst_miso", 32'(miso8), 32'(0));
    check("rst_rx_data", 32'(rx8), 32'(0));
    check("rst_rx_valid", 32'(rxv8), 32'(0));
    check("rst_frame_err", 32'(err8), 32'(0));
    check("rst_busy", 32'(busy8), 32'(0));
    rst_n8 = 1'b1; rst_n16 = 1'b1;
    tick();

    // Frames that end in DONE; a frame left in RD_WAIT would flag frame_err on deselect
    vt[0] = '{{CMD_WR_ADDR, 8'hF0}, 10'h0F0};
    vt[1] = '{{CMD_WR_DATA, 8'hA5}, 10'h1A5};
    vt[2] = '{{CMD_RD_DATA, 8'h00}, 10'h300};
    vt[3] = '{{CMD_WR_ADDR, 8'h01}, 10'h001};
    for (int i = 0; i < 4; i++) begin
      clr();
      send(0, 18'(vt[i].frame), 10, 10);
      check("tbl_rx_valid_cnt", 32'(nv[0]), 32'(1));
      check("tbl_rx_data", 32'(rxl8), 32'(vt[i].exp_rx));
      check("tbl_miso_quiet", 32'(mh[0]), 32'(0));
      check("tbl_busy_in_frame", 32'(bl[0]), 32'(0));
      end_frame(0);
      check("tbl_no_err", 32'(ne[0]), 32'(0));
      check("tbl_busy_idle", 32'(busy8), 32'(0));
    end

    // Read-data frame with A5 returned after a short wait
    clr();
    send(0, 18'({CMD_RD_DATA, 8'h00}), 10, 10);
    check("rd_rx_valid_cnt", 32'(nv[0]), 32'(1));
    check("rd_rx_data", 32'(rxl8), 32'h300);
    repeat (3) tick();
    check("rd_wait_busy", 32'(busy8), 32'(1));
    check("rd_wait_miso", 32'(mh[0]), 32'(0));
    a5 = 8'hA5;
    txd8 = a5; txv8 = 1'b1;
    tick();
    txv8 = 1'b0; txd8 = '0;
    for (int i = 0; i < 8; i++) begin
      check("rd_miso_bit", 32'(miso8), 32'(a5[7-i]));
      tick();
    end
    check("rd_miso_after", 32'(miso8), 32'(0));
    end_frame(0);
    check("rd_no_err", 32'(ne[0]), 32'(0));

    // Address then read-data with tx_valid withheld: timeout 16 cycles after RD_WAIT entry
    clr();
    send(0, 18'({CMD_RD_ADDR, 8'hF0}), 10, 10);
    end_frame(0);
    check("ra_rx_data", 32'(rxl8), 32'h2F0);
    check("ra_no_err", 32'(ne[0]), 32'(0));
    clr();
    send(0, 18'({CMD_RD_DATA, 8'h00}), 10, 10);
    check("to_rx_valid_cnt", 32'(nv[0]), 32'(1));
    k = 0; found = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (err8 && !found) begin found = 1'b1; k = i; end
    end
    check("to_err_cycle", 32'(k), 32'(16));
    check("to_err_cnt", 32'(ne[0]), 32'(1));
    check("to_miso_quiet", 32'(mh[0]), 32'(0));
    end_frame(0);
    check("to_no_extra_err", 32'(ne[0]), 32'(1));

    // Abort after 5 bits of a read frame: error, no rx, rx_data and rd_addr_seen unchanged
    clr();
    send(0, 18'({CMD_RD_DATA, 8'hFF}), 10, 5);
    end_frame(0);
    check("ab_err_cnt", 32'(ne[0]), 32'(1));
    check("ab_rx_valid_cnt", 32'(nv[0]), 32'(0));
    check("ab_rx_hold", 32'(rx8), 32'h300);
    check("ab_busy", 32'(busy8), 32'(0));
    // Deselect on the edge of the final bit
    clr();
    send(0, 18'({CMD_WR_ADDR, 8'h55}), 10, 9);
    end_frame(0);
    check("ab9_err_cnt", 32'(ne[0]), 32'(1));
    check("ab9_rx_valid_cnt", 32'(nv[0]), 32'(0));
    clr();
    send(0, 18'({CMD_RD_DATA, 8'h00}), 10, 10);
    end_frame(0);
    check("ab_seen_kept_rx", 32'(nv[0]), 32'(1));
    check("ab_seen_kept_err", 32'(ne[0]), 32'(0));

    // 16-bit LSB-first instance
    clr();
    send(1, {CMD_RD_ADDR, rev16(16'h1234)}, 18, 18);
    check("w16_rx_data", 32'(rxl16), 32'h21234);
    end_frame(1);
    check("w16_no_err", 32'(ne[1]), 32'(0));
    clr();
    send(1, {CMD_RD_DATA, rev16(16'h00C3)}, 18, 18);
    check("w16_rd_rx_data", 32'(rxl16), 32'h300C3);
    p16 = 16'h8001;
    txd16 = p16; txv16 = 1'b1;
    tick();
    txv16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("w16_miso_bit", 32'(miso16), 32'(p16[i]));
      tick();
    end
    check("w16_miso_after", 32'(miso16), 32'(0));
    end_frame(1);
    check("w16_rd_no_err", 32'(ne[1]), 32'(0));

    // Async reset in the middle of RD_SHIFT
    clr();
    send(1, {CMD_RD_ADDR, rev16(16'h0001)}, 18, 18);
    end_frame(1);
    send(1, {CMD_RD_DATA, rev16(16'h0000)}, 18, 18);
    txd16 = 16'hFFFF; txv16 = 1'b1;
    tick();
    txv16 = 1'b0;
    tick(); tick();
    check("rs_miso_before", 32'(miso16), 32'(1));
    check("rs_busy_before", 32'(busy16), 32'(1));
    #2;
    rst_n16 = 1'b0;
    #1;
    check("rs_miso_async", 32'(miso16), 32'(0));
    check("rs_busy_async", 32'(busy16), 32'(0));
    ss16 = 1'b1;
    tick();
    rst_n16 = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
Parametrised SPI slave. It deserialises MOSI frames of {2-bit command, DATA_W-bit payload} into a parallel rx word for the RAM/controller. For read-data frames, it serialises the returned tx word onto MISO. It supersedes the fixed 8-bit slave and adds the following:
- configurable width and bit order
- a tx-wait timeout
- frame-abort error reporting
All logic runs on the single system clock; SS_n and MOSI are sampled on rising CLK.

Parameters:
DATA_W, 8, payload width; frame width FRAME_W = DATA_W+2
LSB_FIRST, 0, 0: MOSI/MISO MSB-first; 1: LSB-first (applies to payload bits only; command bits always come first, cmd[1] then cmd[0])
TX_TIMEOUT, 16, max cycles waited for tx_valid after a read-data frame completes; 0 disables the timeout

Ports:
CLK  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  slave select, active low
MOSI  in  1  serial data from master
MISO  out  1  serial data to master
rx_data  out  FRAME_W  received frame {cmd, payload}
rx_valid  out  1  one-cycle strobe, rx_data valid
tx_data  in  DATA_W  read data to return
tx_valid  in  1  tx_data valid, sampled only in RD_WAIT
frame_err  out  1  one-cycle strobe on abort or timeout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - MISO=0, rx_data=0, rx_valid=0, frame_err=0
  - rd_addr_seen=0, all counters 0
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, DONE.
- IDLE -> CHK_CMD on the first edge SS_n=0. MOSI is ignored in that cycle (start cycle).
- CHK_CMD: samples MOSI as cmd[1] into the shift register, then branches:
  - 0 -> WRITE
  - 1 and rd_addr_seen=0 -> READ_ADD
  - 1 and rd_addr_seen=1 -> READ_DATA
- WRITE / READ_ADD / READ_DATA: sample the remaining FRAME_W-1 bits, one per cycle.
  - The edge sampling the final bit loads rx_data with the full frame and drives rx_valid=1 for exactly one cycle.
  - Payload is placed per LSB_FIRST, so rx_data[DATA_W-1:0] is always the natural-order word.
- After the final bit:
  - WRITE -> DONE
  - READ_ADD -> DONE, rd_addr_seen<=1
  - READ_DATA -> RD_WAIT, rd_addr_seen<=0
- RD_WAIT: on the first edge with tx_valid=1, latch tx_data and go to RD_SHIFT.
  - tx_valid in any other state is ignored.
  - If TX_TIMEOUT>0 and TX_TIMEOUT cycles elapse without tx_valid: frame_err pulse, go to DONE.
- RD_SHIFT: MISO drives one latched bit per cycle (MSB-first unless LSB_FIRST), DATA_W cycles, then DONE.
  - The first bit is visible in the cycle after the latching edge.
- MISO=0 in every state except RD_SHIFT.
- DONE: idle inside the frame until SS_n=1; extra MOSI bits are ignored.
- SS_n=1 in any state -> IDLE on the next edge, counters cleared.
  - If the state was CHK_CMD, WRITE, READ_*, RD_WAIT or RD_SHIFT (frame incomplete): frame_err one-cycle pulse.
  - No rx_valid for the aborted frame; rd_addr_seen unchanged by the aborted frame.
- SS_n rising on the same edge as the final bit: the frame counts as aborted (frame_err, no rx_valid).
- rx_data holds its last value until the next completed frame.
- Bit counter width: $clog2(FRAME_W+1); timeout counter width: $clog2(TX_TIMEOUT+1).

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_state_e
  - command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
- One sub-module, spi_tx_serializer (parameter DATA_W, LSB_FIRST):
  - inputs: load strobe, data, shift enable
  - outputs: MISO bit, done flag
- The FSM, rx shift register and timeout counter stay in the top module.

Test Plan:
- DATA_W=8, SS_n low, MOSI 10'b00_1111_0000 MSB-first -> one rx_valid, rx_data=10'h0F0, busy=1, MISO=0 throughout.
- MOSI 10'b10_1111_0000, then a new frame 10'b11_0000_0000 followed by tx_valid=1 with tx_data=8'hA5 -> rx_valid with rx_data=10'h2F0, then rx_valid with rx_data=10'h300. After that, MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
- With rd_addr_seen=0, send 10'b11_0000_0000 -> routed to READ_ADD: rx_valid, rx_data=10'h300, no MISO activity, next read frame goes to READ_DATA.
- Raise SS_n after 5 bits of a write frame -> frame_err high for 1 cycle, no rx_valid, state IDLE, rx_data unchanged.
- Complete a read-data frame, withhold tx_valid -> frame_err exactly 16 cycles after entering RD_WAIT, MISO stays 0.
- DATA_W=16, LSB_FIRST=1, read-data with tx_data=16'h8001 -> MISO 1, then fourteen 0s, then 1. Async reset asserted mid-RD_SHIFT -> MISO=0 immediately, busy=0.
